ps2_rx_fifo: RTL and testbench
==============================

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 SHALL have parameter FILTER_LEN, default 8, number of consecutive equal samples before the filtered PS2_clk changes.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000, idle clk_50mhz cycles (1 ms) that abort a partial frame.
REQ-004 SHALL have port clk_50mhz, input, 1: sole clock.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port PS2_clk, input, 1: asynchronous PS/2 clock line.
REQ-007 SHALL have port PS2_Data, input, 1: asynchronous PS/2 data line.
REQ-008 SHALL have port rd_en, input, 1: pop the head byte.
REQ-009 SHALL have port rd_data, output, 8: head byte, first-word-fall-through.
REQ-010 SHALL have port empty, output, 1: FIFO holds no bytes.
REQ-011 SHALL have port full, output, 1: FIFO holds DEPTH bytes.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1: occupancy, 0..DEPTH.
REQ-013 SHALL have port overflow, output, 1: sticky flag, set when a byte is dropped.
REQ-014 SHALL have port frame_err, output, 1: one-cycle pulse for a rejected or aborted frame.

Function
REQ-015 SHALL pass PS2_clk and PS2_Data through 2-FF synchronisers.
REQ-016 SHALL change filtered clock only after FILTER_LEN consecutive equal synchronised samples; shorter glitches have no effect.
REQ-017 SHALL sample synchronised PS2_Data on each falling edge of the filtered clock.
REQ-018 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-019 In IDLE, an edge sampling data=0 (start bit) SHALL go to DATA and clear the bit counter; data=1 SHALL be ignored.
REQ-020 In DATA, it SHALL shift in 8 bits LSB first, then go to PARITY.
REQ-021 In PARITY, it SHALL capture the parity bit, then go to STOP.
REQ-022 In STOP, a valid frame (stop=1, parity accepted per REQ-032/033) SHALL push the byte; otherwise it SHALL pulse frame_err; either way it SHALL return to IDLE.
REQ-023 In any state other than IDLE, TIMEOUT_CYCLES cycles with no falling edge SHALL return to IDLE and pulse frame_err; the partial byte is discarded.
REQ-024 empty SHALL deassert and rd_data SHALL be valid in the cycle after the stop-bit edge is detected.
REQ-025 rd_en with !empty SHALL pop; rd_data SHALL show the next entry the following cycle; rd_en while empty SHALL be ignored.
REQ-026 Simultaneous push and pop SHALL leave count unchanged, including when full; no overflow.
REQ-027 A push while full without pop SHALL drop the byte and set overflow, held until rst.
REQ-028 Pointers SHALL wrap modulo DEPTH; rd_data SHALL be 8'h00 while empty.

Reset
REQ-029 Reset SHALL be sampled on the rising clk_50mhz edge only.
REQ-030 On reset: FSM=IDLE, pointers and count=0, empty=1, full=0, overflow=0, frame_err=0, rd_data=8'h00, filter state=1 (line idle high).
REQ-031 Reset mid-frame SHALL abandon the frame without frame_err; reception resumes at the next start bit after rst falls.

Configuration
REQ-032 With PS2_PARITY_CHECK_EN defined, a frame SHALL be accepted only if data plus parity bit has odd weight.
REQ-033 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be sampled and ignored; only the stop bit qualifies the frame.

Structure
REQ-034 Package ps2_pkg SHALL hold the FSM state typedef, PS2_DATA_BITS=8, and the default parameter constants.
REQ-035 Storage SHALL be a sub-module ps2_sync_fifo (DEPTH, width 8); synchroniser, filter and FSM stay in the top.

Verification
REQ-036 Frame 0x1C with parity 0 and stop 1 -> empty=0, count=1, rd_data=0x1C; after rd_en, empty=1.
REQ-037 With macro defined, 0x1C with parity 1 -> frame_err pulse, empty stays 1. Without macro -> 0x1C is pushed.
REQ-038 With DEPTH=16, send 17 frames 0x00..0x10 -> full=1, overflow=1; 16 reads return 0x00..0x0F in order.
REQ-039 Start bit plus 4 data bits, then clock idle -> frame_err pulse at TIMEOUT_CYCLES; a following 0xF0 frame is received correctly.
REQ-040 A 3-cycle low glitch on PS2_clk while IDLE -> no state change; rst asserted mid-frame -> all outputs at reset values, no frame_err.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and defaults for the PS/2 receive path: FSM states, frame
// geometry and the odd-parity helper.
package ps2_pkg;

   localparam int PS2_DATA_BITS              = 8;
   localparam int PS2_DEFAULT_DEPTH          = 16;
   localparam int PS2_DEFAULT_FILTER_LEN     = 8;
   localparam int PS2_DEFAULT_TIMEOUT_CYCLES = 50000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } ps2_state_e;

   // PS/2 uses odd parity: data bits plus parity bit must have odd weight.
   function automatic logic odd_weight(input logic [PS2_DATA_BITS-1:0] data,
                                       input logic                     par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word-fall-through byte FIFO with sticky overflow; a push while full is
// dropped unless a pop happens in the same cycle.
module ps2_sync_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = PS2_DEFAULT_DEPTH,
   parameter int WIDTH = PS2_DATA_BITS
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q;
   logic             do_push, do_pop;

   assign empty_o    = (count_q == '0);
   assign full_o     = (count_q == CW'(DEPTH));
   assign do_pop     = rd_en_i & ~empty_o;
   assign do_push    = wr_en_i & (~full_o | do_pop);
   assign count_o    = count_q;
   assign overflow_o = overflow_q;
   assign rd_data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register updating from
         // the pre-edge values, independent of statement order.
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         if (wr_en_i && full_o && !do_pop) overflow_q <= 1'b1;
      end
   end

   // NOTE: storage has no reset; empty_o masks stale entries, and leaving it
   // out lets the array map onto plain RAM.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, glitch filter, frame FSM and a
// byte FIFO. Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH          = PS2_DEFAULT_DEPTH,
   parameter int FILTER_LEN     = PS2_DEFAULT_FILTER_LEN,
   parameter int TIMEOUT_CYCLES = PS2_DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                   clk_50mhz,
   input  logic                   rst,
   input  logic                   PS2_clk,
   input  logic                   PS2_Data,
   input  logic                   rd_en,
   output logic [7:0]             rd_data,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   frame_err
);

`ifdef PS2_PARITY_CHECK_EN
   localparam bit PARITY_CHECK = 1'b1;
`else
   localparam bit PARITY_CHECK = 1'b0;
`endif

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BW = $clog2(PS2_DATA_BITS);

   logic clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
   logic filt_q, filt_prev_q;
   logic [FW-1:0] filt_cnt_q;
   logic fall;

   ps2_state_e              state_q;
   logic [BW-1:0]           bit_cnt_q;
   logic [PS2_DATA_BITS-1:0] shift_q;
   logic                    parity_q;
   logic [TW-1:0]           to_cnt_q;
   logic                    frame_err_q;
   logic                    frame_ok, push;

   // Idle PS/2 lines are high, so reset to 1 to avoid a false falling edge.
   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
      end else begin
         clk_meta_q  <= PS2_clk;
         clk_sync_q  <= clk_meta_q;
         data_meta_q <= PS2_Data;
         data_sync_q <= data_meta_q;
      end
   end

   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
         filt_cnt_q  <= '0;
      end else begin
         filt_prev_q <= filt_q;
         if (clk_sync_q == filt_q) begin
            filt_cnt_q <= '0;
         end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_q     <= clk_sync_q;
            filt_cnt_q <= '0;
         end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
         end
      end
   end

   assign fall     = filt_prev_q & ~filt_q;
   assign frame_ok = data_sync_q & (~PARITY_CHECK | odd_weight(shift_q, parity_q));
   // Push straight from the stop-bit edge so the byte is visible next cycle.
   assign push     = fall & (state_q == ST_STOP) & frame_ok;

   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         to_cnt_q    <= '0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         if (state_q == ST_IDLE || fall) to_cnt_q <= '0;
         else                            to_cnt_q <= to_cnt_q + 1'b1;

         case (state_q)
            ST_IDLE: begin
               if (fall && !data_sync_q) begin
                  state_q   <= ST_DATA;
                  bit_cnt_q <= '0;
               end
            end
            ST_DATA: begin
               if (fall) begin
                  shift_q   <= {data_sync_q, shift_q[PS2_DATA_BITS-1:1]};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == BW'(PS2_DATA_BITS - 1)) state_q <= ST_PARITY;
               end
            end
            ST_PARITY: begin
               if (fall) begin
                  parity_q <= data_sync_q;
                  state_q  <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (fall) begin
                  if (!frame_ok) frame_err_q <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         if (state_q != ST_IDLE && !fall && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q     <= ST_IDLE;
            frame_err_q <= 1'b1;
         end
      end
   end

   assign frame_err = frame_err_q;

   ps2_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (PS2_DATA_BITS)
   ) u_fifo (
      .clk_i      (clk_50mhz),
      .rst_i      (rst),
      .wr_en_i    (push),
      .wr_data_i  (shift_q),
      .rd_en_i    (rd_en),
      .rd_data_o  (rd_data),
      .empty_o    (empty),
      .full_o     (full),
      .count_o    (count),
      .overflow_o (overflow)
   );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomised bench for ps2_rx_fifo against a queue-based model of the PS/2
// framing rules and FIFO occupancy.
module tb_ps2_rx_fifo;

   localparam int DEPTH      = 16;
   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT    = 400;
   localparam int HALF       = 20;
   localparam int CW         = $clog2(DEPTH) + 1;

   logic          clk_50mhz = 1'b0;
   logic          rst       = 1'b1;
   logic          PS2_clk   = 1'b1;
   logic          PS2_Data  = 1'b1;
   logic          rd_en     = 1'b0;
   logic [7:0]    rd_data;
   logic          empty, full, overflow, frame_err;
   logic [CW-1:0] count;

   logic [7:0] exp_q[$];
   logic       exp_ovf = 1'b0;
   int         exp_err  = 0;
   int         err_seen = 0;
   int         n_cmp    = 0;
   int         n_mis    = 0;

   ps2_rx_fifo #(
      .DEPTH          (DEPTH),
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk_50mhz (clk_50mhz),
      .rst       (rst),
      .PS2_clk   (PS2_clk),
      .PS2_Data  (PS2_Data),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .overflow  (overflow),
      .frame_err (frame_err)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   // Counts cycles with frame_err high, so a stretched pulse shows up too.
   always @(negedge clk_50mhz) if (frame_err) err_seen++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk_50mhz);
   endtask

   task automatic check_all(input string tag);
      check({tag, ".count"},    32'(count),    32'(exp_q.size()));
      check({tag, ".empty"},    32'(empty),    32'(exp_q.size() == 0));
      check({tag, ".full"},     32'(full),     32'(exp_q.size() == DEPTH));
      check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
      check({tag, ".rd_data"},  32'(rd_data),  (exp_q.size() == 0) ? 32'h0 : 32'(exp_q[0]));
      check({tag, ".frame_err"}, 32'(err_seen), 32'(exp_err));
   endtask

   // Model: a frame is good if stop=1 (and, with checking, odd total weight).
   task automatic model_frame(input logic [7:0] data, input logic par, input logic stop);
      bit good;
`ifdef PS2_PARITY_CHECK_EN
      good = stop && ((^data ^ par) == 1'b1);
`else
      good = stop;
`endif
      if (!good)                   exp_err++;
      else if (exp_q.size() < DEPTH) exp_q.push_back(data);
      else                         exp_ovf = 1'b1;
   endtask

   task automatic send_bits(input logic [10:0] bits, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         PS2_Data = bits[i];
         wait_cycles(HALF);
         PS2_clk = 1'b0;
         wait_cycles(HALF);
         PS2_clk = 1'b1;
      end
      PS2_Data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
      send_bits({stop, par, data, 1'b0}, 11);
      wait_cycles(30);
      model_frame(data, par, stop);
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      wait_cycles(1);
      rd_en = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
   endtask

   task automatic do_reset();
      rst = 1'b1;
      PS2_clk  = 1'b1;
      PS2_Data = 1'b1;
      wait_cycles(3);
      rst = 1'b0;
      exp_q.delete();
      exp_ovf = 1'b0;
      wait_cycles(2);
   endtask

   initial begin
      int  lat;
      bit  seen;
      logic [7:0] d;
      logic       p, s;

      do_reset();
      check_all("reset");

      // Basic frame, with a bound on how soon the byte appears after the stop edge.
      send_bits({1'b0, 1'b0, 8'h1C, 1'b0}, 10);
      PS2_Data = 1'b1;
      wait_cycles(HALF);
      PS2_clk = 1'b0;
      seen = 1'b0;
      lat  = 0;
      while (!seen && lat < HALF) begin
         wait_cycles(1);
         lat++;
         if (!empty) seen = 1'b1;
      end
      check("stop_to_push_bound", 32'(seen), 32'd1);
      wait_cycles(HALF);
      PS2_clk = 1'b1;
      wait_cycles(30);
      model_frame(8'h1C, 1'b0, 1'b1);
      check_all("frame_1c");
      pop_one();
      check_all("pop_1c");
      pop_one();
      check_all("pop_empty");

      send_frame(8'h1C, 1'b1, 1'b1);
      check_all("bad_parity");
      while (exp_q.size() > 0) pop_one();
      check_all("drain_parity");

      send_frame(8'hA5, ~^8'hA5, 1'b0);
      check_all("bad_stop");

      for (int i = 0; i <= 16; i++) send_frame(8'(i), ~^8'(i), 1'b1);
      check_all("fill17");
      for (int i = 0; i < 16; i++) begin
         check("order", 32'(rd_data), 32'(i));
         pop_one();
      end
      check_all("drained");

      // A short low glitch with data low would start a frame if it got through.
      PS2_Data = 1'b0;
      PS2_clk  = 1'b0;
      wait_cycles(3);
      PS2_clk  = 1'b1;
      PS2_Data = 1'b1;
      wait_cycles(TIMEOUT + 50);
      check_all("glitch");

      // Start plus four data bits, then silence.
      send_bits({6'b0, 4'b1011, 1'b0}, 5);
      wait_cycles(TIMEOUT - 100);
      check_all("timeout_early");
      wait_cycles(150);
      exp_err++;
      check_all("timeout");
      send_frame(8'hF0, ~^8'hF0, 1'b1);
      check_all("after_timeout");
      pop_one();

      do_reset();
      check_all("reset2");
      for (int n = 0; n < 25; n++) begin
         d = 8'($urandom);
         p = ~^d;
         if ($urandom_range(0, 4) == 0) p = ~p;
         s = ($urandom_range(0, 5) != 0);
         send_frame(d, p, s);
         check_all("rand_rx");
         repeat ($urandom_range(0, 2)) begin
            pop_one();
            check_all("rand_pop");
         end
      end

      // Reset in the middle of a frame: nothing kept, no error pulse.
      send_frame(8'h3C, ~^8'h3C, 1'b1);
      send_bits({7'b0, 3'b101, 1'b0}, 4);
      PS2_Data = 1'b0;
      PS2_clk  = 1'b0;
      wait_cycles(HALF);
      do_reset();
      check_all("mid_reset");
      wait_cycles(TIMEOUT + 50);
      check_all("mid_reset_quiet");
      send_frame(8'h5A, ~^8'h5A, 1'b1);
      check_all("post_reset_rx");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
